pixel_sink_buffer: RTL
======================

Name: pixel_sink_buffer

Overview:
- Downstream neighbour of the box plotter (oX/oY/oColour/oPlot producer).
- Accepts one pixel write per cycle, range-checks it and converts (x,y) to a linear framebuffer address: addr = y*160 + x.
- Buffers writes in a small first-word-fall-through FIFO, then drains them to a video-memory write port that can stall via iMemReady.
- The plotter has no backpressure, so overflow is detected and flagged rather than prevented.

Parameters:
- X_SCREEN_PIXELS, 160, screen width; valid x is 0..159.
- Y_SCREEN_PIXELS, 120, screen height; valid y is 0..119.
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- ADDR_W, 15, framebuffer address width; 19200 < 2^15.
- COLOUR_W, 3, colour width.

Ports:
- iClock  in  1  single clock; all state changes on its rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iX  in  8  pixel x from the plotter.
- iY  in  7  pixel y from the plotter.
- iColour  in  COLOUR_W  pixel colour.
- iPlot  in  1  pixel write strobe; one pixel per high cycle.
- iMemReady  in  1  memory accepts the write this cycle.
- iClearOverflow  in  1  synchronous clear of oOverflow.
- oAddr  out  ADDR_W  FIFO head address.
- oData  out  COLOUR_W  FIFO head colour.
- oWrEn  out  1  head valid; a write transfers when oWrEn && iMemReady.
- oFull  out  1  FIFO holds DEPTH entries.
- oEmpty  out  1  FIFO holds 0 entries.
- oCount  out  log2(DEPTH)+1  occupancy, 0..DEPTH.
- oOverflow  out  1  sticky: a valid pixel was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, iReset=1): clears pointers, stage register and flags.
  - oWrEn=0, oEmpty=1, oFull=0, oCount=0, oOverflow=0, oAddr=0, oData=0.
  - In-flight pixels are discarded; there is no flush.
- Stage A (registered), cycle N: if iPlot=1 and iX<X_SCREEN_PIXELS and iY<Y_SCREEN_PIXELS, register:
  - valid=1;
  - addr = (iY<<7)+(iY<<5)+iX, computed at ADDR_W width with no overflow possible;
  - colour = iColour.
  - Otherwise valid=0.
  - Out-of-range pixels, for example x=160 or y=120, are silently dropped.
- Stage B, cycle N+1: a valid stage-A entry pushes into the FIFO.
  - Push is allowed if not full, or if full with a pop in the same cycle.
  - If full and no pop: the entry is dropped and oOverflow is set at N+2.
- Pop: happens when oWrEn=1 and iMemReady=1.
  - Because the FIFO is first-word-fall-through, the next entry is on oAddr/oData in the following cycle.
- Latency: with the FIFO empty and iMemReady=1, a pixel presented at edge N appears on oWrEn/oAddr/oData after edge N+2. Throughput is 1 pixel/cycle.
- Simultaneous push and pop: oCount is unchanged; this is legal at full and at empty+1.
- Push into an empty FIFO with iMemReady=1: the write port still sees the entry one cycle later. There is no bypass.
- oOverflow: set stays until iClearOverflow=1 or reset.
  - If set and clear occur in the same cycle, set wins.
- oAddr/oData: hold the last head value when empty; they are don't-care while oWrEn=0.
- Pointers wrap modulo DEPTH. oCount never exceeds DEPTH or underflows.
- iMemReady while empty: no effect.

Optional Feature:
- Macro: PIXEL_SINK_CLIP_COUNT_EN.
- Defined: adds output oClipCount[7:0].
  - Increments once per iPlot cycle whose coordinates are out of range.
  - Saturates at 255.
  - Cleared by reset and by iClearOverflow.
- Undefined: the port and the counter are absent. Out-of-range pixels are dropped silently and all other behaviour is identical.

Decomposition:
- Shared package pixel_pkg holds:
  - X_SCREEN_PIXELS, Y_SCREEN_PIXELS, ADDR_W, COLOUR_W;
  - the pixel entry typedef {addr, colour};
  - the xy-to-address function. The box plotter and the VGA memory wrapper reuse these.
- One sub-module, pixel_fifo: a generic FWFT FIFO with parameters DEPTH and WIDTH, ports push/pop/full/empty/count.
  - The top level contains stage A, the push/overflow logic and the optional clip counter.

Test Plan:
- Reset, then a single pixel (x=3, y=2, colour=5) with iMemReady=1 → 2 edges later oWrEn=1, oAddr=323, oData=5 for exactly one cycle; then oEmpty=1.
- Corner pixels (0,0) and (159,119) → oAddr=0 and oAddr=19199.
- Out-of-range pixels (160,0) and (0,120) → no oWrEn; with PIXEL_SINK_CLIP_COUNT_EN, oClipCount=2.
- iMemReady=0 while driving 16 consecutive valid pixels → oFull=1, oCount=16, oOverflow=0.
  - A 17th pixel → oOverflow=1, oCount=16.
  - Release iMemReady → 16 writes in original order.
- FIFO full with a push and pop in the same cycle → oCount stays 16 and oOverflow stays 0.
- iReset asserted mid-drain with 8 entries buffered → immediately oWrEn=0, oCount=0, oEmpty=1; after release, new pixels flow normally.

Source files
------------

// File: rtl/pixel_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pkg
// Shared screen geometry, pixel entry type and (x,y) -> framebuffer address
// helpers. Used by the pixel sink buffer and by the neighbouring plotter and
// VGA memory wrapper so that they all agree on one address mapping.
// -----------------------------------------------------------------------------
package pixel_pkg;

    localparam int X_SCREEN_PIXELS = 160;
    localparam int Y_SCREEN_PIXELS = 120;
    localparam int ADDR_W          = 15;   // 160*120 = 19200 < 2^15
    localparam int COLOUR_W        = 3;
    localparam int X_W             = 8;
    localparam int Y_W             = 7;

    // Limits at coordinate width so range compares stay width-matched.
    localparam logic [X_W-1:0] X_LIMIT = X_W'(X_SCREEN_PIXELS);
    localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(Y_SCREEN_PIXELS);

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } pixel_entry_t;

    localparam int ENTRY_W = $bits(pixel_entry_t);

    function automatic logic in_range(input logic [X_W-1:0] x,
                                      input logic [Y_W-1:0] y);
        return (x < X_LIMIT) && (y < Y_LIMIT);
    endfunction

    // y*160 + x as two shifts and adds; max 119*160+159 = 19199 fits ADDR_W.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] w_x;
        logic [ADDR_W-1:0] w_y;
        w_x = ADDR_W'(x);
        w_y = ADDR_W'(y);
        return (w_y << 7) + (w_y << 5) + w_x;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
// Generic first-word-fall-through FIFO. The head entry is visible on oHead
// whenever oEmpty=0; a pop consumes it and the next entry appears the cycle
// after. A push while full is accepted only if a pop happens in the same cycle.
// While empty, oHead holds the last popped entry (zero after reset).
//
// Parameters: DEPTH (power of 2, >= 2), WIDTH (entry width)
// Ports:
//   iClock, iReset   clock, asynchronous active-high reset
//   iPush, iPushData write request and data
//   iPop             read request (ignored while empty)
//   oHead            head entry
//   oFull, oEmpty    occupancy flags
//   oCount           occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic                     iPush,
    input  logic [WIDTH-1:0]         iPushData,
    input  logic                     iPop,
    output logic [WIDTH-1:0]         oHead,
    output logic                     oFull,
    output logic                     oEmpty,
    output logic [$clog2(DEPTH):0]   oCount
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_last;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = iPop && !w_empty;
    assign w_do_push = iPush && (!w_full || w_do_pop);

    // NOTE: storage is deliberately left out of reset; only the pointers and
    // count define which entries are live, so resetting the array buys nothing.
    always_ff @(posedge iClock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= iPushData;
        end
    end

    // NOTE: every sequential update uses <= so all registers see the values
    // from before the edge, independent of statement order.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign oHead  = w_empty ? r_last : r_mem[r_rd_ptr];
    assign oFull  = w_full;
    assign oEmpty = w_empty;
    assign oCount = r_count;

endmodule

// File: rtl/pixel_sink_buffer.sv
// -----------------------------------------------------------------------------
// pixel_sink_buffer
// Receives one pixel write per cycle from the box plotter, drops off-screen
// pixels, converts (x,y) to a linear framebuffer address and queues the write
// in a FWFT FIFO that drains to a stallable video-memory write port. The
// plotter cannot be stalled, so a pixel arriving at a full FIFO is dropped and
// recorded in the sticky oOverflow flag.
//
// Optional build macro PIXEL_SINK_CLIP_COUNT_EN adds oClipCount, a saturating
// count of off-screen pixel strobes (cleared by reset and iClearOverflow).
//
// Ports:
//   iClock, iReset        clock, asynchronous active-high reset
//   iX, iY, iColour       pixel from the plotter
//   iPlot                 pixel strobe
//   iMemReady             memory accepts the write this cycle
//   iClearOverflow        clears oOverflow (and oClipCount when present)
//   oAddr, oData, oWrEn   memory write port (transfer on oWrEn && iMemReady)
//   oFull, oEmpty, oCount FIFO occupancy
//   oOverflow             sticky dropped-pixel flag
// -----------------------------------------------------------------------------
module pixel_sink_buffer
    import pixel_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   iClock,
    input  logic                   iReset,
    input  logic [X_W-1:0]         iX,
    input  logic [Y_W-1:0]         iY,
    input  logic [COLOUR_W-1:0]    iColour,
    input  logic                   iPlot,
    input  logic                   iMemReady,
    input  logic                   iClearOverflow,
    output logic [ADDR_W-1:0]      oAddr,
    output logic [COLOUR_W-1:0]    oData,
    output logic                   oWrEn,
    output logic                   oFull,
    output logic                   oEmpty,
    output logic [$clog2(DEPTH):0] oCount,
`ifdef PIXEL_SINK_CLIP_COUNT_EN
    output logic [7:0]             oClipCount,
`endif
    output logic                   oOverflow
);

    logic         w_in_range;
    logic         r_stage_valid;
    pixel_entry_t r_stage_entry;
    pixel_entry_t w_head;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_drop;
    logic         r_overflow;

    assign w_in_range = in_range(iX, iY);

    // Stage A: range check and address conversion, registered.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_stage_valid <= 1'b0;
            r_stage_entry <= '0;
        end else begin
            r_stage_valid <= iPlot && w_in_range;
            r_stage_entry <= '{addr: xy_to_addr(iX, iY), colour: iColour};
        end
    end

    assign w_pop  = !w_empty && iMemReady;
    // A pop in the same cycle frees a slot, so only full-without-pop drops.
    assign w_drop = r_stage_valid && w_full && !w_pop;

    pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .iClock    (iClock),
        .iReset    (iReset),
        .iPush     (r_stage_valid),
        .iPushData (r_stage_entry),
        .iPop      (w_pop),
        .oHead     (w_head),
        .oFull     (w_full),
        .oEmpty    (w_empty),
        .oCount    (oCount)
    );

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (iClearOverflow) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef PIXEL_SINK_CLIP_COUNT_EN
    logic [7:0] r_clip_count;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_clip_count <= '0;
        end else if (iClearOverflow) begin
            r_clip_count <= '0;
        end else if (iPlot && !w_in_range && (r_clip_count != 8'hFF)) begin
            r_clip_count <= r_clip_count + 8'd1;
        end
    end

    assign oClipCount = r_clip_count;
`endif

    assign oAddr     = w_head.addr;
    assign oData     = w_head.colour;
    assign oWrEn     = !w_empty;
    assign oFull     = w_full;
    assign oEmpty    = w_empty;
    assign oOverflow = r_overflow;

endmodule
